// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: requester 0 (execute) vs requester 1 (multi-cycle unit).
// Build option: define WB_ARB_FAIRNESS_EN to force requester 1 to win after STARVE_LIMIT consecutive denied cycles.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         Clk_Core,
    input  logic                         Rst_Core,
    input  logic                         Req0_Valid,
    output logic                         Req0_Ready,
    input  logic [ADDR_WIDTH-1:0]        Req0_Addr,
    input  logic [DATA_WIDTH-1:0]        Req0_Data,
    input  logic                         Req1_Valid,
    output logic                         Req1_Ready,
    input  logic [ADDR_WIDTH-1:0]        Req1_Addr,
    input  logic [DATA_WIDTH-1:0]        Req1_Data,
    output logic [ADDR_WIDTH-1:0]        Write_Addr_Port_1,
    output logic [DATA_WIDTH-1:0]        Write_Data_Port_1,
    output logic                         Wr_En,
    output logic [(1<<ADDR_WIDTH)-1:0]   Pending_Mask
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // Handshake: a request transfers on a rising edge where Valid && Ready. Valid/Addr/Data hold
    // until accepted; Ready is a function of both Valid inputs, the starvation state and reset only.
    logic grant0;
    logic grant1;
    logic force_req1;

`ifdef WB_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core || !Req1_Valid || Req1_Ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_req1 = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    // Pure fixed priority: requester 1 is never forced to win.
    assign force_req1 = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Rst_Core) begin
            if (Req1_Valid && (force_req1 || !Req0_Valid)) begin
                grant1 = 1'b1;
            end else if (Req0_Valid) begin
                grant0 = 1'b1;
            end
        end
    end

    assign Req0_Ready = grant0;
    assign Req1_Ready = grant1;

    // x0 writes still consume the slot; they just never raise Wr_En.
    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            Write_Addr_Port_1 <= '0;
            Write_Data_Port_1 <= '0;
            Wr_En             <= 1'b0;
        end else if (grant0) begin
            Write_Addr_Port_1 <= Req0_Addr;
            Write_Data_Port_1 <= Req0_Data;
            Wr_En             <= (Req0_Addr != '0);
        end else if (grant1) begin
            Write_Addr_Port_1 <= Req1_Addr;
            Write_Data_Port_1 <= Req1_Data;
            Wr_En             <= (Req1_Addr != '0);
        end else begin
            Wr_En             <= 1'b0;
        end
    end

    always_comb begin
        Pending_Mask = {NUM_REGS{1'b0}};
        if (Req0_Valid && !grant0) begin
            Pending_Mask[Req0_Addr] = 1'b1;
        end
        if (Req1_Valid && !grant1) begin
            Pending_Mask[Req1_Addr] = 1'b1;
        end
        // A write registered just before reset is ignored so the mask shows only the requesters.
        if (Wr_En && !Rst_Core) begin
            Pending_Mask[Write_Addr_Port_1] = 1'b1;
        end
        Pending_Mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// transaction-level model of arbitration, the write port, the pending mask and the register file.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;
    localparam int NR = 1 << AW;
`ifdef WB_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic          Clk_Core = 1'b0;
    logic          Rst_Core = 1'b1;
    logic          Req0_Valid = 1'b0;
    logic          Req0_Ready;
    logic [AW-1:0] Req0_Addr = '0;
    logic [DW-1:0] Req0_Data = '0;
    logic          Req1_Valid = 1'b0;
    logic          Req1_Ready;
    logic [AW-1:0] Req1_Addr = '0;
    logic [DW-1:0] Req1_Data = '0;
    logic [AW-1:0] Write_Addr_Port_1;
    logic [DW-1:0] Write_Data_Port_1;
    logic          Wr_En;
    logic [NR-1:0] Pending_Mask;

    always #5 Clk_Core = ~Clk_Core;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .Clk_Core          (Clk_Core),
        .Rst_Core          (Rst_Core),
        .Req0_Valid        (Req0_Valid),
        .Req0_Ready        (Req0_Ready),
        .Req0_Addr         (Req0_Addr),
        .Req0_Data         (Req0_Data),
        .Req1_Valid        (Req1_Valid),
        .Req1_Ready        (Req1_Ready),
        .Req1_Addr         (Req1_Addr),
        .Req1_Data         (Req1_Data),
        .Write_Addr_Port_1 (Write_Addr_Port_1),
        .Write_Data_Port_1 (Write_Data_Port_1),
        .Wr_En             (Wr_En),
        .Pending_Mask      (Pending_Mask)
    );

    // Register file attached to the write port (not reset, x0 hardwired to zero).
    logic [DW-1:0] rf [NR] = '{default: '0};
    always @(posedge Clk_Core) begin
        if (Wr_En && Write_Addr_Port_1 != '0) rf[Write_Addr_Port_1] <= Write_Data_Port_1;
    end

    // ---------------- model / scoreboard state ----------------
    txn_t          q0[$];
    txn_t          q1[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rf [NR];
    logic          r0_v = 1'b0;
    logic          r1_v = 1'b0;
    logic          rnd  = 1'b0;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_wa = '0;
    logic [DW-1:0] exp_wd = '0;
    int            streak = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc_idx = 0;
    int            r1_acc_cyc = -1;
    int            we_cnt = 0;
    int            we_first = -1;
    int            we_last = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        if (!r0_v && q0.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) r0_v = 1'b1;
        if (!r1_v && q1.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) r1_v = 1'b1;
        Req0_Valid = r0_v;
        Req0_Addr  = r0_v ? q0[0].a : '0;
        Req0_Data  = r0_v ? q0[0].d : '0;
        Req1_Valid = r1_v;
        Req1_Addr  = r1_v ? q1[0].a : '0;
        Req1_Data  = r1_v ? q1[0].d : '0;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge, re-drive after it.
    task automatic cycle();
        int            g;
        logic [NR-1:0] pm;
        txn_t          t;
        @(negedge Clk_Core);
        g = -1;
        if (!Rst_Core) begin
            if (FAIR && r1_v && streak >= SL) g = 1;
            else if (r0_v)                    g = 0;
            else if (r1_v)                    g = 1;
        end
        pm = '0;
        if (r0_v && g != 0) pm[Req0_Addr] = 1'b1;
        if (r1_v && g != 1) pm[Req1_Addr] = 1'b1;
        if (exp_we && !Rst_Core) pm[exp_wa] = 1'b1;
        pm[0] = 1'b0;
        check_eq("req0_ready", Req0_Ready, g == 0);
        check_eq("req1_ready", Req1_Ready, g == 1);
        check_eq("pending_mask", Pending_Mask, pm);
        check_eq("wr_en", Wr_En, exp_we);
        check_eq("wr_addr", Write_Addr_Port_1, exp_wa);
        check_eq("wr_data", Write_Data_Port_1, exp_wd);
        if (Wr_En) begin
            check_eq("sb_write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("sb_write_data", Write_Data_Port_1, exp_q.pop_front());
            we_cnt++;
            if (we_first < 0) we_first = cyc_idx;
            we_last = cyc_idx;
        end
        if (Req1_Ready && r1_acc_cyc < 0) r1_acc_cyc = cyc_idx;
        cyc_idx++;

        @(posedge Clk_Core);
        if (exp_we && exp_wa != '0) exp_rf[exp_wa] = exp_wd;
        if (Rst_Core) begin
            exp_we = 1'b0;
            exp_wa = '0;
            exp_wd = '0;
            streak = 0;
        end else begin
            if (g == 0) begin
                t = q0.pop_front();
                r0_v = 1'b0;
            end else if (g == 1) begin
                t = q1.pop_front();
                r1_v = 1'b0;
            end
            if (g >= 0) begin
                exp_wa = t.a;
                exp_wd = t.d;
                exp_we = (t.a != '0);
                if (exp_we) exp_q.push_back(t.d);
            end else begin
                exp_we = 1'b0;
            end
            streak = (r1_v && g != 1) ? streak + 1 : 0;
        end
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < NR; i++) check_eq(tag, rf[i], exp_rf[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        for (int i = 0; i < NR; i++) exp_rf[i] = '0;

        repeat (2) @(posedge Clk_Core);
        #1;
        cycle();                 // outputs checked while reset is still high
        Rst_Core = 1'b0;

        // Single write to x5
        q0.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        drive();
        run(3);
        check_eq("x5_value", rf[5], 32'hDEADBEEF);

        // x0 write is accepted but never reaches the register file
        q1.push_back('{a: 5'd0, d: 32'h12345678});
        drive();
        run(3);
        check_eq("x0_value", rf[0], 0);

        // Same-address collision: later-accepted requester 1 value survives
        q0.push_back('{a: 5'd7, d: 32'h1});
        q1.push_back('{a: 5'd7, d: 32'h2});
        drive();
        run(4);
        check_eq("x7_value", rf[7], 32'h2);

        // Both requesters held: starvation behaviour
        for (int i = 0; i < 10; i++) q0.push_back('{a: AW'(8 + i), d: $urandom});
        q1.push_back('{a: 5'd20, d: $urandom});
        cyc_idx = 1;
        r1_acc_cyc = -1;
        drive();
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 40) begin
            cycle();
            guard++;
        end
        check_eq("starve_bounded", guard < 40, 1);
        check_eq("req1_accept_cycle", r1_acc_cyc, FAIR ? SL + 1 : 11);
        run(2);

        // Reset on the same edge as a requester 0 accept of x3
        q0.push_back('{a: 5'd3, d: 32'hAA});
        drive();
        Rst_Core = 1'b1;
        cycle();
        q0.delete();
        r0_v = 1'b0;
        drive();
        cycle();
        Rst_Core = 1'b0;
        run(3);
        check_eq("x3_value", rf[3], 0);

        // 31 back-to-back writes to x1..x31
        for (int i = 1; i < NR; i++) q0.push_back('{a: AW'(i), d: $urandom});
        we_cnt = 0;
        we_first = -1;
        we_last = -1;
        cyc_idx = 0;
        drive();
        run(NR + 2);
        check_eq("b2b_pulses", we_cnt, NR - 1);
        check_eq("b2b_no_gaps", we_last - we_first + 1, NR - 1);
        readback_all("b2b_readback");

        // Random traffic on both requesters
        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 1) == 1)
                q0.push_back('{a: AW'($urandom_range(0, NR - 1)), d: $urandom});
            if (q1.size() < 3 && $urandom_range(0, 2) == 0)
                q1.push_back('{a: AW'($urandom_range(0, NR - 1)), d: $urandom});
            cycle();
        end
        rnd = 1'b0;
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 100) begin
            cycle();
            guard++;
        end
        check_eq("drain_bounded", guard < 100, 1);
        run(3);
        readback_all("rand_readback");
        check_eq("sb_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
